// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// line-level constants for start, stop and idle bits.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Byte-side interface of the serial frame receiver: received byte with
// valid/ready handshake plus the error pulses.
// Optional macro SERIAL_RX_PARITY_EN adds the parity_err pulse.
interface serial_frame_receiver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             frame_err;
  logic             overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic             parity_err;
`endif

  // Receiver side: produces bytes and error pulses, consumes ready.
  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
`ifdef SERIAL_RX_PARITY_EN
    output parity_err,
`endif
    input  data_ready
  );

  // Consumer side: sees bytes and error pulses, drives ready.
  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
`ifdef SERIAL_RX_PARITY_EN
    input  parity_err,
`endif
    output data_ready
  );

endinterface

// File: rtl/serial_frame_receiver_rx_hold_reg.sv
// One-entry valid/ready holding register for received bytes. A load that
// arrives while the entry is full and not being consumed is dropped and
// flagged with a one-cycle overrun pulse.
module rx_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  // Next-state: consume on valid&ready, then a load either refills the
  // (possibly just freed) entry or is dropped as an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      if (valid_q && !ready_i) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = data_i;
        valid_d = 1'b1;
      end
    end
  end

  // Entry and overrun pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: detects a start bit on strobed samples of serial_in,
// deserialises WIDTH data bits, checks the stop bit and hands good bytes to a
// one-entry valid/ready holding register.
// Optional macro SERIAL_RX_PARITY_EN inserts an even-parity bit before the
// stop bit and adds the parity_err pulse.
module serial_frame_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     serial_in,
  serial_frame_receiver_if.master  bus
);

  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ferr_q, ferr_d;
  logic             deliver;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_err_q, par_err_d;
  logic             perr_q, perr_d;
`endif

  // Frame FSM and deserialiser; everything advances only on strobed cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    deliver = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_err_d = par_err_q;
    perr_d    = 1'b0;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (serial_in == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end
        DATA: begin
          if (MSB_FIRST != 0) begin
            shift_d = {shift_q[WIDTH-2:0], serial_in};
          end else begin
            shift_d = {serial_in, shift_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          par_err_d = (serial_in != (^shift_q));
          state_d   = STOP;
        end
`endif
        STOP: begin
          // A bad stop bit wins over a parity error; neither delivers.
          state_d = IDLE;
          if (serial_in != STOP_BIT) begin
            ferr_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          end else if (par_err_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            deliver = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, counter, shift register and error pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q <= par_err_d;
      perr_q    <= perr_d;
`endif
    end
  end

  rx_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (deliver),
    .data_i   (shift_q),
    .ready_i  (bus.data_ready),
    .data_o   (bus.data_out),
    .valid_o  (bus.data_valid),
    .overrun_o(bus.overrun)
  );

  assign bus.frame_err = ferr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (WIDTH=8, MSB_FIRST=1).
module tb_serial_frame_receiver;

  logic clk;
  logic reset;
  logic enable;
  logic serial_in;
  logic data_ready;

  int n_checks;
  int n_fail;

  serial_frame_receiver_if #(.WIDTH(8)) bus ();
  assign bus.data_ready = data_ready;

  serial_frame_receiver #(
    .WIDTH    (8),
    .MSB_FIRST(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .serial_in(serial_in),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       rdy_stop;
    logic       drain;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobed bit, then gap non-strobed cycles. Called at a negedge.
  task automatic send_bit(input logic b, input int gap);
    serial_in = b;
    enable    = 1'b1;
    @(negedge clk);
    enable    = 1'b0;
    serial_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Whole frame; returns on the negedge right after the stop-bit strobe.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                            input logic rdy_stop, input logic bad_par);
    send_bit(1'b0, gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^d) ^ bad_par, gap);
`else
    if (bad_par) $display("note: parity not compiled in");
`endif
    serial_in  = stop;
    enable     = 1'b1;
    data_ready = rdy_stop;
    @(negedge clk);
    enable     = 1'b0;
    serial_in  = 1'b1;
    data_ready = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    enable     = 1'b0;
    serial_in  = 1'b1;
    data_ready = 1'b0;

    //                data   stop gap rdy drain exp    vld ferr ovr
    vecs[0] = '{8'hA5, 1'b1, 0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 3, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h11, 1'b1, 0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h22, 1'b1, 0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h22, 1'b1, 0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};

    // Reset state
    #3;
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data",  32'(bus.data_out),   32'd0);
    check("rst_ferr",  32'(bus.frame_err),  32'd0);
    check("rst_ovr",   32'(bus.overrun),    32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, vecs[i].rdy_stop, 1'b0);
      check($sformatf("v%0d_valid", i), 32'(bus.data_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("v%0d_data", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_ferr", i), 32'(bus.frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d_ovr", i),  32'(bus.overrun),   32'(vecs[i].exp_ovr));
`ifdef SERIAL_RX_PARITY_EN
      check($sformatf("v%0d_perr", i), 32'(bus.parity_err), 32'd0);
`endif
      // Following cycle: pulses gone, optional consume
      data_ready = vecs[i].drain;
      @(negedge clk);
      data_ready = 1'b0;
      check($sformatf("v%0d_valid_next", i), 32'(bus.data_valid),
            32'(vecs[i].exp_valid & ~vecs[i].drain));
      check($sformatf("v%0d_ferr_next", i), 32'(bus.frame_err), 32'd0);
      check($sformatf("v%0d_ovr_next", i),  32'(bus.overrun),   32'd0);
      if (vecs[i].exp_valid)
        check($sformatf("v%0d_data_next", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
    end

    // Reset in the middle of a frame, with a byte held in the output register
    send_frame(8'h5A, 1'b1, 0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(bus.data_valid), 32'd1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.data_valid), 32'd0);
    check("midrst_data",  32'(bus.data_out),   32'd0);
    check("midrst_ferr",  32'(bus.frame_err),  32'd0);
    check("midrst_ovr",   32'(bus.overrun),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_frame(8'h0F, 1'b1, 0, 1'b0, 1'b0);
    check("post_rst_valid", 32'(bus.data_valid), 32'd1);
    check("post_rst_data",  32'(bus.data_out),   32'h0F);
    check("post_rst_ferr",  32'(bus.frame_err),  32'd0);
    check("post_rst_ovr",   32'(bus.overrun),    32'd0);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    check("post_rst_drained", 32'(bus.data_valid), 32'd0);

`ifdef SERIAL_RX_PARITY_EN
    // Wrong parity bit: pulse, no delivery; then correct parity delivers
    send_frame(8'h07, 1'b1, 0, 1'b0, 1'b1);
    check("par_bad_perr",  32'(bus.parity_err), 32'd1);
    check("par_bad_valid", 32'(bus.data_valid), 32'd0);
    check("par_bad_ovr",   32'(bus.overrun),    32'd0);
    @(negedge clk);
    check("par_bad_perr_next", 32'(bus.parity_err), 32'd0);
    send_frame(8'h07, 1'b1, 0, 1'b0, 1'b0);
    check("par_ok_perr",  32'(bus.parity_err), 32'd0);
    check("par_ok_valid", 32'(bus.data_valid), 32'd1);
    check("par_ok_data",  32'(bus.data_out),   32'h07);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
